// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module      : aes_round_ctrl
// Description : Iterative AES encryption sequencer. Holds the 128-bit cipher
//               state and the round counter, steps an external round-function
//               datapath once per cycle, requests round keys by index from an
//               external key store, and applies AddRoundKey on every state
//               update. Blocks enter and leave over valid/ready handshakes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NR         number of rounds (10, 12 or 14 for AES-128/192/256)
//   KIW        width of the round-key index
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   plaintext block valid
//   in_ready   controller can accept a block (IDLE only)
//   data_in    plaintext block
//   out_valid  ciphertext valid (DONE only)
//   out_ready  downstream accepts ciphertext
//   data_out   ciphertext, always the state register
//   key_idx    round-key index requested this cycle
//   round_key  key for key_idx, combinational from the key store
//   rf_in      state presented to the round function (state register)
//   rf_last    final round: round function must skip MixColumns
//   rf_out     round-function result, combinational
//   busy       controller is not IDLE
// Build option
//   AES_CTRL_ABORT_EN  adds input 'abort': in ROUND or DONE it discards the
//                      block, clears state and counter and returns to IDLE.
//                      rst takes priority over abort.
// ============================================================================

`default_nettype none

module aes_round_ctrl #(
    parameter int NR  = 10,
    parameter int KIW = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef AES_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     data_out,
    output logic [KIW-1:0]   key_idx,
    input  logic [127:0]     round_key,
    output logic [127:0]     rf_in,
    output logic             rf_last,
    input  logic [127:0]     rf_out,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [KIW-1:0] c_cnt_zero   = '0;
    localparam logic [KIW-1:0] c_cnt_one    = KIW'(1);
    localparam logic [KIW-1:0] c_last_round = KIW'(NR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_e           r_state_q;
    state_e           w_state_d;
    logic [127:0]     r_data_q;
    logic [127:0]     w_data_d;
    logic [KIW-1:0]   r_cnt_q;
    logic [KIW-1:0]   w_cnt_d;

    logic             w_abort;
    logic             w_last_round;

`ifdef AES_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last_round = (r_cnt_q == c_last_round);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_data_q  <= '0;
            r_cnt_q   <= c_cnt_zero;
        end else begin
            r_state_q <= w_state_d;
            r_data_q  <= w_data_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_data_d  = r_data_q;
        w_cnt_d   = r_cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        key_idx   = c_cnt_zero;
        rf_last   = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                // in_ready is masked during reset so no block can be
                // handshaked on an edge that discards it.
                in_ready = !rst;
                key_idx  = c_cnt_zero;
                if (in_valid) begin
                    // Initial AddRoundKey with round key 0.
                    w_data_d  = data_in ^ round_key;
                    w_cnt_d   = c_cnt_one;
                    w_state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                key_idx  = r_cnt_q;
                rf_last  = w_last_round;
                w_data_d = rf_out ^ round_key;
                if (w_last_round) begin
                    // Counter parks at NR; it is cleared on the output
                    // handshake so key_idx never wraps.
                    w_state_d = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + c_cnt_one;
                end
            end

            ST_DONE: begin
                // An abort in this cycle kills the block, so ciphertext is
                // not offered on the edge that discards it.
                out_valid = !rst && !w_abort;
                if (out_ready) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = c_cnt_zero;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = c_cnt_zero;
            end
        endcase

        // Abort overrides all in-flight progress; in IDLE it is a no-op.
        if (w_abort && (r_state_q != ST_IDLE)) begin
            w_state_d = ST_IDLE;
            w_data_d  = '0;
            w_cnt_d   = c_cnt_zero;
        end
    end

    // ------------------------------------------------------------------------
    // Direct outputs
    // ------------------------------------------------------------------------
    assign data_out = r_data_q;
    assign rf_in    = r_data_q;
    assign busy     = (r_state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Self-checking bench for aes_round_ctrl (NR=10). Models the
//               AES-128 round function and key store around the DUT and keeps
//               a whole-block AES-128 reference; a monitor scoreboards every
//               ciphertext, latency and key-index sequence.
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module tb_aes_round_ctrl;

    localparam int NR  = 10;
    localparam int KIW = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     data_in;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     data_out;
    logic [KIW-1:0]   key_idx;
    logic [127:0]     round_key;
    logic [127:0]     rf_in;
    logic             rf_last;
    logic [127:0]     rf_out;
    logic             busy;
`ifdef AES_CTRL_ABORT_EN
    logic             abort;
`endif

    aes_round_ctrl #(.NR(NR), .KIW(KIW)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef AES_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .key_idx   (key_idx),
        .round_key (round_key),
        .rf_in     (rf_in),
        .rf_last   (rf_last),
        .rf_out    (rf_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------------
    // AES-128 arithmetic
    // ------------------------------------------------------------------------
    logic [7:0]   sbox [0:255];
    logic [127:0] rk_tab [0:15];
    logic [127:0] cur_key;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_entry(input int x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // SubBytes + ShiftRows; byte i of the block is row i%4, column i/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox[s[127-8*(r+4*((c+r)%4)) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
        return last ? sub_shift(s) : mix_columns(sub_shift(s));
    endfunction

    function automatic logic [127:0] round_key_of(input logic [127:0] key, input int idx);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    // Whole-block reference encryption.
    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ round_key_of(key, 0);
        for (int r = 1; r <= NR; r++)
            s = round_fn(s, r == NR) ^ round_key_of(key, r);
        return s;
    endfunction

    // Environment: combinational key store and round-function datapath.
    assign round_key = rk_tab[key_idx];
    assign rf_out    = round_fn(rf_in, rf_last);

    // ------------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [127:0] exp_q [$];
    int           kseq [$];
    bit           rfl  [$];
    bit           seen_out;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           prev_acc_cyc = 0;
    int           hs_cyc = 0;
    int           n_acc = 0;
    logic [127:0] last_out;
    bit           rnd_ready_en = 0;

    // Monitor / scoreboard. A block is "in flight" from its input handshake
    // until its output handshake; the controller must be ready exactly when
    // nothing is in flight.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            exp_q.delete();
            kseq.delete();
            rfl.delete();
        end
`ifdef AES_CTRL_ABORT_EN
        else if (abort && exp_q.size() != 0) begin
            chk("abort_out_valid", out_valid, 0);
            exp_q.delete();
            kseq.delete();
            rfl.delete();
        end
`endif
        else begin
            chk("in_ready", in_ready, exp_q.size() == 0);
            chk("busy", busy, exp_q.size() != 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out_valid: got data_out %h expected no output", data_out);
                end else begin
                    chk("data_out", data_out, exp_q[0]);
                    if (!seen_out) begin
                        seen_out = 1;
                        chk("latency", cyc - acc_cyc, NR + 1);
                        chk("key_seq_len", kseq.size(), NR + 1);
                        for (int i = 0; i < kseq.size() && i <= NR; i++) begin
                            chk("key_idx_seq", kseq[i], i);
                            chk("rf_last_seq", rfl[i], i == NR);
                        end
                    end
                    if (out_ready) begin
                        last_out = data_out;
                        void'(exp_q.pop_front());
                        hs_cyc = cyc;
                    end
                end
            end else if (exp_q.size() != 0) begin
                kseq.push_back(int'(key_idx));
                rfl.push_back(rf_last);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(aes128(cur_key, data_in));
                prev_acc_cyc = acc_cyc;
                acc_cyc = cyc;
                n_acc++;
                seen_out = 0;
                kseq.delete();
                rfl.delete();
                kseq.push_back(int'(key_idx));
                rfl.push_back(rf_last);
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_ready_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all leave time at posedge + 1)
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        for (int i = 0; i < 16; i++)
            rk_tab[i] = (i <= NR) ? round_key_of(k, i) : 128'h0;
        cur_key = k;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_accept(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no accept expected accept within 300 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        in_valid = 1'b1;
        data_in  = d;
        wait_accept("send_timeout");
        in_valid = 1'b0;
        data_in  = rnd128();
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got busy expected idle within 300 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_state(input string name);
        @(negedge clk);
        chk({name, "_in_ready"}, in_ready, 1);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_key_idx"}, key_idx, 0);
        chk({name, "_rf_last"}, rf_last, 0);
        chk({name, "_data_out"}, data_out, 0);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [127:0] a;
        logic [127:0] b;
        int           acc_before;
        int           t;

        for (int x = 0; x < 256; x++) sbox[x] = sbox_entry(x);
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
`ifdef AES_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        load_key(128'h000102030405060708090a0b0c0d0e0f);
        tick(3);
        rst = 1'b0;
        check_idle_state("reset");

        // FIPS-197 appendix C.1 vector.
        send(128'h00112233445566778899aabbccddeeff);
        wait_done();
        chk("fips197_ct", last_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Backpressure: ciphertext held 5 cycles while a second block waits.
        load_key(rnd128());
        a = rnd128();
        b = rnd128();
        out_ready = 1'b0;
        send(a);
        in_valid = 1'b1;
        data_in  = b;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bp_out_valid_seen", out_valid, 1);
        acc_before = n_acc;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        chk("bp_no_accept_in_done", n_acc, acc_before);
        out_ready = 1'b1;
        wait_accept("bp_second_accept");
        in_valid = 1'b0;
        chk("bp_accept_after_handshake", acc_cyc - hs_cyc, 1);
        wait_done();

        // Back-to-back with in_valid held high.
        a = rnd128();
        b = rnd128();
        in_valid = 1'b1;
        data_in  = a;
        wait_accept("b2b_first");
        data_in  = b;
        wait_accept("b2b_second");
        in_valid = 1'b0;
        chk("b2b_spacing", acc_cyc - prev_acc_cyc, NR + 2);
        wait_done();

        // Reset in the middle of round 5.
        send(rnd128());
        tick(4);
        chk("mid_key_idx", key_idx, 5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_idle_state("mid_reset");
        send(rnd128());
        wait_done();

`ifdef AES_CTRL_ABORT_EN
        // Abort in round 3.
        send(rnd128());
        tick(2);
        chk("abort_key_idx", key_idx, 3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_idle_state("abort");
        // Abort together with reset.
        send(rnd128());
        tick(2);
        abort = 1'b1;
        rst   = 1'b1;
        tick(1);
        abort = 1'b0;
        rst   = 1'b0;
        check_idle_state("abort_rst");
        send(rnd128());
        wait_done();
`endif

        // Randomised traffic with random keys, gaps and output stalls.
        rnd_ready_en = 1;
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                wait_done();
                load_key(rnd128());
            end
            tick($urandom_range(0, 3));
            send(rnd128());
        end
        wait_done();
        rnd_ready_en = 0;
        tick(1);
        out_ready = 1'b1;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: got simulation still running expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES encryption sequencer.
- Owns the 128-bit state register and the round counter.
- Drives an external round-function datapath (SubBytes/ShiftRows/MixColumns) and requests round keys from a key store by index.
- Performs the AddRoundKey XOR on every register update.
- Sits between the block-level valid/ready stream interface and the combinational round logic and key RAM.

Parameters:
- NR, 10, number of rounds. Legal values are 10, 12, 14 (AES-128/192/256).
- KIW, 4, width of the round-key index.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext block valid
- in_ready  out  1  controller can accept a block
- data_in  in  128  plaintext block
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts ciphertext
- data_out  out  128  ciphertext (equals the state register)
- key_idx  out  KIW  round-key index requested this cycle
- round_key  in  128  key for key_idx, combinational from the key store, same cycle
- rf_in  out  128  state fed to the round function (equals the state register)
- rf_last  out  1  final round: round function must bypass MixColumns
- rf_out  in  128  round-function result, combinational, same cycle
- busy  out  1  FSM not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge.
- Reset state: FSM=IDLE, state_reg=0, round_cnt=0.
  - While rst is high, in_ready and out_valid are 0.
  - From the first cycle after reset: in_ready=1, out_valid=0, busy=0, key_idx=0, rf_last=0, data_out=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, key_idx=0.
  - On in_valid: state_reg <= data_in ^ round_key (initial AddRoundKey), round_cnt <= 1, go to ROUND.
- ROUND:
  - in_ready=0, key_idx=round_cnt, rf_last=(round_cnt==NR).
  - Each cycle: state_reg <= rf_out ^ round_key.
  - If round_cnt==NR, go to DONE; otherwise round_cnt++.
- DONE:
  - out_valid=1, data_out=state_reg.
  - data_out is held stable while out_ready=0.
  - On out_ready: go to IDLE, round_cnt <= 0. state_reg is not cleared.
- Latency: the accept edge is counted as cycle 0. out_valid asserts at cycle NR+1, so 11 cycles for NR=10.
- Throughput: one block per NR+2 cycles with out_ready held high.
- DONE→IDLE has no fast path: in_ready=0 in DONE even if out_ready=1. The next block is accepted no earlier than the cycle after the output handshake.
- in_valid while busy: ignored. data_in is not sampled; the upstream holds it per valid/ready rules.
- round_cnt is KIW bits wide.
  - It never exceeds NR and never wraps.
  - key_idx takes exactly the values 0..NR, once each per block, in order.
- rst mid-operation (ROUND or DONE): everything returns to reset values at that edge. The in-flight block is discarded and no out_valid pulse is produced.
- rf_last is asserted in exactly one cycle per block.

Optional Feature:
- Macro: AES_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in ROUND or DONE: next edge goes to IDLE, state_reg <= 0, round_cnt <= 0. No out_valid pulse from that point.
  - abort in IDLE has no effect.
  - rst has priority over abort.
- Not defined: the abort port does not exist and the FSM is exactly as above.

Test Plan:
- FIPS-197 vector: bench models the round function and key store; key 000102030405060708090a0b0c0d0e0f, data_in 00112233445566778899aabbccddeeff, out_ready=1 → out_valid at cycle 11, data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Key sequencing on the same vector: key_idx sequence 0,1,…,10; rf_last high only while key_idx=10.
- Backpressure: out_ready=0 for 5 cycles in DONE → data_out stable, in_ready=0, second in_valid not accepted. Second block is accepted only the cycle after out_ready=1.
- Back-to-back with in_valid held high, two blocks → accept edges 12 cycles apart, both ciphertexts correct.
- rst pulse at round 5 → next cycle FSM in IDLE, in_ready=1, no out_valid; a new block then encrypts correctly.
- With AES_CTRL_ABORT_EN: abort at round 3 → IDLE next cycle, data_out=0, no out_valid. Abort asserted together with rst → reset behaviour.
